eth_tx_frame_arbiter: RTL

- Frame-granular round-robin arbiter that shares the single 8-bit TX AXI-stream input of the 1G MAC between PORTS requesters.
- Sits in the MAC tx_clk domain, directly upstream of the MAC tx_axis interface.
- Once a source is granted, it holds the grant until that source's tlast is accepted.
- A stall watchdog aborts a granted frame whose source stops supplying data: it emits an errored tlast beat, then discards the remainder of that source's frame.

---
 rtl/eth_tx_frame_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/eth_tx_frame_arbiter.sv
// rtl/eth_tx_frame_arbiter.sv - frame-granular round-robin arbiter feeding the 1G MAC tx stream
// Grants one source per frame, forwards through a single output register, aborts stalled frames.
module eth_tx_frame_arbiter #(
    parameter int  PORTS   = 4,
    parameter int  TIMEOUT = 255,
    localparam int GW      = $clog2(PORTS)
) (
    input  logic               tx_clk,
    input  logic               tx_rst,
    input  logic [PORTS*8-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]   s_axis_tvalid,
    output logic [PORTS-1:0]   s_axis_tready,
    input  logic [PORTS-1:0]   s_axis_tlast,
    input  logic [PORTS-1:0]   s_axis_tuser,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    output logic               grant_valid,
    output logic [GW-1:0]      grant_index,
    output logic               frame_abort
);
    localparam int            CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX      = CW'(TIMEOUT);
    localparam logic [GW-1:0] LAST_PORT = GW'(PORTS - 1);
    localparam logic [GW:0]   PORTS_W   = (GW + 1)'(PORTS);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic          tuser_q, tuser_d;
    logic          abort_q, abort_d;

    logic          out_ready;
    logic          g_valid, g_last, g_user;
    logic [7:0]    g_data;
    logic          found;
    logic [GW-1:0] scan_idx;
    logic [GW:0]   scan_sum;
    logic [PORTS-1:0] tready;

    assign out_ready = !tvalid_q || m_axis_tready;
    assign g_valid   = s_axis_tvalid[grant_q];
    assign g_last    = s_axis_tlast[grant_q];
    assign g_user    = s_axis_tuser[grant_q];
    assign g_data    = s_axis_tdata[{grant_q, 3'b000} +: 8];

    // Scan starts one past the last grant so the previous winner has lowest priority.
    always_comb begin
        found    = 1'b0;
        scan_idx = grant_q;
        scan_sum = '0;
        for (int i = 1; i <= PORTS; i++) begin
            scan_sum = {1'b0, grant_q} + (GW + 1)'(i);
            if (scan_sum >= PORTS_W) begin
                scan_sum = scan_sum - PORTS_W;
            end
            if (!found && s_axis_tvalid[scan_sum[GW-1:0]]) begin
                found    = 1'b1;
                scan_idx = scan_sum[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        tvalid_d = tvalid_q && !m_axis_tready;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        abort_d  = 1'b0;
        tready   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = scan_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                tready[grant_q] = out_ready;
                if (g_valid && out_ready) begin
                    tvalid_d = 1'b1;
                    tdata_d  = g_data;
                    tlast_d  = g_last;
                    tuser_d  = g_user;
                    cnt_d    = '0;
                    if (g_last) begin
                        state_d = IDLE;
                    end
                end else if (TIMEOUT > 0 && !g_valid) begin
                    if (cnt_q == TMAX) begin
                        // Terminate the frame with an errored beat so the MAC discards it.
                        if (out_ready) begin
                            tvalid_d = 1'b1;
                            tdata_d  = 8'h00;
                            tlast_d  = 1'b1;
                            tuser_d  = 1'b1;
                            abort_d  = 1'b1;
                            cnt_d    = '0;
                            state_d  = DRAIN;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                tready[grant_q] = 1'b1;
                if (g_valid && g_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q  <= IDLE;
            grant_q  <= LAST_PORT;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= 8'h00;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            abort_q  <= abort_d;
        end
    end

    assign s_axis_tready = tready;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign grant_valid   = (state_q != IDLE);
    assign grant_index   = grant_q;
    assign frame_abort   = abort_q;
endmodule
